bnn_weight_loader: RTL and testbench

//  Upstream feeder for the 8-8-4 BNN core's serial weight port. Accepts weight bytes

---
 rtl/bnn_pkg.sv | 15 +
 rtl/bnn_weight_loader.sv | 143 ++++++++++++++
 tb/tb_bnn_weight_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN weight loader.
package bnn_pkg;
    localparam int NUM_NEURONS_DEF = 12;
    localparam int NIBBLE_W        = 4;
    localparam int BYTE_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LO,
        HI,
        DONE,
        CHK
    } loader_state_t;
endpackage

// File: rtl/bnn_weight_loader.sv
// Streams weight bytes into the BNN core as low/high nibble pairs with load_en.
// Optional trailing checksum byte when WEIGHT_CSUM_EN is defined.
import bnn_pkg::*;

module bnn_weight_loader #(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int CNT_W       = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BYTE_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                load_en,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic                csum_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NEURONS - 1);

    loader_state_t     state, state_nx;
    logic [BYTE_W-1:0] byte_buf;
    logic              abort_pend;
    logic              pend_now;
    logic              last_byte;

    assign pend_now  = abort_pend | abort;
    assign last_byte = (count == LAST_IDX);
    assign busy      = (state == WAIT) || (state == LO) || (state == HI) || (state == CHK);

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        load_en  = 1'b0;
        nibble   = '0;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) state_nx = WAIT;
            end
            WAIT: begin
                s_ready = 1'b1;
                if (s_valid)     state_nx = LO;
                else if (abort)  state_nx = IDLE;
            end
            // The high nibble always follows the low one so the core never sees half a byte.
            LO: begin
                load_en  = 1'b1;
                nibble   = byte_buf[NIBBLE_W-1:0];
                state_nx = HI;
            end
            HI: begin
                load_en = 1'b1;
                nibble  = byte_buf[BYTE_W-1:NIBBLE_W];
                s_ready = !last_byte && !pend_now;
                if (s_valid && s_ready) state_nx = LO;
`ifdef WEIGHT_CSUM_EN
                else if (last_byte)     state_nx = CHK;
`else
                else if (last_byte)     state_nx = DONE;
`endif
                else if (pend_now)      state_nx = IDLE;
                else                    state_nx = WAIT;
            end
`ifdef WEIGHT_CSUM_EN
            CHK: begin
                s_ready = 1'b1;
                if (abort)        state_nx = IDLE;
                else if (s_valid) state_nx = DONE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

`ifdef WEIGHT_CSUM_EN
    logic [BYTE_W-1:0] xacc;

    always_ff @(posedge clk) begin
        if (reset) begin
            xacc     <= '0;
            csum_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start && !abort) begin
                    xacc     <= '0;
                    csum_err <= 1'b0;
                end
                WAIT:    if (s_valid) xacc <= xacc ^ s_data;
                HI:      if (s_valid && s_ready) xacc <= xacc ^ s_data;
                CHK: begin
                    if (abort)        csum_err <= 1'b0;
                    else if (s_valid) csum_err <= (s_data != xacc);
                end
                default: ;
            endcase
        end
    end
`else
    assign csum_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_buf   <= '0;
            abort_pend <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: if (start && !abort) begin
                    count      <= '0;
                    done       <= 1'b0;
                    abort_pend <= 1'b0;
                end
                WAIT: if (s_valid) begin
                    byte_buf   <= s_data;
                    abort_pend <= abort;
                end
                LO: abort_pend <= abort_pend | abort;
                HI: begin
                    count      <= count + CNT_W'(1);
                    abort_pend <= 1'b0;
                    if (s_valid && s_ready) byte_buf <= s_data;
`ifndef WEIGHT_CSUM_EN
                    else if (last_byte)     done <= 1'b1;
`endif
                end
`ifdef WEIGHT_CSUM_EN
                CHK: if (!abort && s_valid) done <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_weight_loader.sv
// Scoreboard bench for bnn_weight_loader; checksum scenario runs when WEIGHT_CSUM_EN is defined.
module tb_bnn_weight_loader;
    localparam int N = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready, load_en, busy, done, csum_err;
    logic [3:0] nibble;
    logic [4:0] count;

    bnn_weight_loader #(.NUM_NEURONS(N), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .load_en(load_en), .nibble(nibble), .busy(busy), .done(done),
        .count(count), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sb_q[$];
    int  fb = 0, le_cnt = 0, run = 0, max_run = 0;
    logic hs = 1'b0, prev_hs = 1'b0;
    logic [3:0] first_nib[2];

    // One clock: monitor at negedge (scoreboard push/pop), return just after posedge.
    task automatic tick();
        logic [3:0] e;
        @(negedge clk);
        if (prev_hs) begin
            vectors++;
            if (s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL lo_s_ready: got %b want 0", s_ready);
            end
        end
        if (load_en) begin
            if (le_cnt < 2) first_nib[le_cnt] = nibble;
            le_cnt++;
            run++;
            if (run > max_run) max_run = run;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_load_en: nibble %h with empty scoreboard", nibble);
            end else begin
                e = sb_q.pop_front();
                if (nibble !== e) begin
                    miscompares++;
                    $display("FAIL nibble: got %h want %h", nibble, e);
                end
            end
        end else begin
            run = 0;
            vectors++;
            if (nibble !== 4'h0) begin
                miscompares++;
                $display("FAIL idle_nibble: got %h want 0", nibble);
            end
        end
        hs = s_valid && s_ready && !reset;
        if (hs && fb < N) begin
            sb_q.push_back(s_data[3:0]);
            sb_q.push_back(s_data[7:4]);
            fb++;
        end
        prev_hs = hs && !reset;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        fb = 0; le_cnt = 0; run = 0; max_run = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_frame(input logic [7:0] b [N], input int gap);
        int i = 0, bud = 0;
        while (i < N && bud < 400) begin
            s_data = b[i];
            s_valid = 1'b1;
            tick();
            bud++;
            if (hs) begin
                i++;
                s_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        s_valid = 1'b0;
        if (i < N) begin
            miscompares++;
            $display("FAIL feed_timeout: accepted %0d want %0d", i, N);
        end
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] b [N]);
        logic [7:0] x = '0;
        for (int i = 0; i < N; i++) x ^= b[i];
        return x;
    endfunction

    // Sends the trailing checksum byte when the checksum feature is built.
    task automatic close_frame(input logic [7:0] c);
`ifdef WEIGHT_CSUM_EN
        int bud = 0;
        s_data = c;
        s_valid = 1'b1;
        do begin tick(); bud++; end while (!hs && bud < 50);
        s_valid = 1'b0;
        if (!hs) begin
            miscompares++;
            $display("FAIL csum_timeout: checksum byte %h not accepted", c);
        end
        tick();
`else
        s_data = c;
        tick();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if ({load_en, nibble, busy, done, count, s_ready, csum_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: le=%b nib=%h busy=%b done=%b cnt=%0d rdy=%b cerr=%b want all 0",
                     load_en, nibble, busy, done, count, s_ready, csum_err);
        end
    endtask

    task automatic test_stream();
        logic [7:0] b [N];
        b[0] = 8'h5A;
        for (int i = 1; i < N; i++) b[i] = 8'(i * 37 + 3);
        start_frame();
        feed_frame(b, 0);
        tick(); tick();
        vectors++;
        if (le_cnt !== 24 || max_run !== 24) begin
            miscompares++;
            $display("FAIL stream_run: le=%0d run=%0d want 24/24", le_cnt, max_run);
        end
        vectors++;
        if (first_nib[0] !== 4'hA || first_nib[1] !== 4'h5) begin
            miscompares++;
            $display("FAIL first_byte: got %h,%h want a,5", first_nib[0], first_nib[1]);
        end
`ifdef WEIGHT_CSUM_EN
        vectors++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL enter_chk: busy=%b rdy=%b done=%b want 1,1,0", busy, s_ready, done);
        end
        close_frame(xor_of(b));
`else
        vectors++;
        if (done !== 1'b1 || count !== 5'd12 || busy !== 1'b0 || csum_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_done: done=%b cnt=%0d busy=%b cerr=%b want 1,12,0,0",
                     done, count, busy, csum_err);
        end
`endif
    endtask

    task automatic test_gaps();
        logic [7:0] b [N];
        for (int i = 0; i < N; i++) b[i] = 8'($urandom_range(0, 255));
        start_frame();
        feed_frame(b, 4);
        tick(); tick();
        close_frame(xor_of(b));
        vectors++;
        if (le_cnt !== 24 || max_run !== 2) begin
            miscompares++;
            $display("FAIL gap_pairs: le=%0d run=%0d want 24/2", le_cnt, max_run);
        end
        vectors++;
        if (done !== 1'b1 || count !== 5'd12 || sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL gap_done: done=%b cnt=%0d q=%0d want 1,12,0", done, count, sb_q.size());
        end
    endtask

    task automatic test_abort();
        int i = 0, bud = 0;
        start_frame();
        while (i < 3 && bud < 50) begin
            s_data = 8'(8'h30 + i);
            s_valid = 1'b1;
            tick();
            bud++;
            if (hs) i++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || count !== 5'd3 || done !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b cnt=%0d done=%b rdy=%b want 0,3,0,0",
                     busy, count, done, s_ready);
        end
        repeat (8) tick();
        s_valid = 1'b0;
        vectors++;
        if (le_cnt !== 6 || sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL abort_le: le=%0d q=%0d want 6,0", le_cnt, sb_q.size());
        end
    endtask

    task automatic test_after_done();
        logic [7:0] b [N];
        for (int i = 0; i < N; i++) b[i] = 8'(8'hC0 ^ i);
        start_frame();
        feed_frame(b, 0);
        tick(); tick();
        close_frame(xor_of(b));
        s_data = 8'hEE;
        s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL done_s_ready: cycle %0d got %b want 0", k, s_ready);
            end
        end
        s_valid = 1'b0;
        vectors++;
        if (done !== 1'b1 || count !== 5'd12 || le_cnt !== 24) begin
            miscompares++;
            $display("FAIL done_hold: done=%b cnt=%0d le=%0d want 1,12,24", done, count, le_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int i = 0, bud = 0;
        start_frame();
        while (i < 7 && bud < 50) begin
            s_data = 8'(8'h70 + i);
            s_valid = 1'b1;
            tick();
            bud++;
            if (hs) i++;
        end
        s_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (load_en !== 1'b0 || busy !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid: le=%b busy=%b cnt=%0d want 0,0,0", load_en, busy, count);
        end
        vectors++;
        if (le_cnt !== 14) begin
            miscompares++;
            $display("FAIL reset_mid_le: got %0d want 14", le_cnt);
        end
        sb_q.delete();
        tick();
    endtask

`ifdef WEIGHT_CSUM_EN
    task automatic test_csum();
        logic [7:0] b [N];
        for (int i = 0; i < N; i++) b[i] = 8'(i + 1);
        start_frame();
        feed_frame(b, 0);
        tick(); tick();
        close_frame(8'h0C);
        vectors++;
        if (csum_err !== 1'b0 || done !== 1'b1 || le_cnt !== 24) begin
            miscompares++;
            $display("FAIL csum_good: cerr=%b done=%b le=%0d want 0,1,24", csum_err, done, le_cnt);
        end
        start_frame();
        feed_frame(b, 0);
        tick(); tick();
        close_frame(8'h00);
        vectors++;
        if (csum_err !== 1'b1 || done !== 1'b1 || le_cnt !== 24) begin
            miscompares++;
            $display("FAIL csum_bad: cerr=%b done=%b le=%0d want 1,1,24", csum_err, done, le_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_abort();
        test_after_done();
        test_reset_mid();
`ifdef WEIGHT_CSUM_EN
        test_csum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
